// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter branch predictor with a
// fetch-to-execute tracking pipeline and optional statistics.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   pc_F, is_branch_F   - fetch PC and "is conditional branch" flag
//   stall               - pipeline freeze
//   resolve_valid_EX    - a branch resolves in EX this cycle
//   taken_EX            - actual outcome of the resolving branch
//   branch_en_F         - predict taken in fetch
//   branch_en_EX        - mispredict, redirect required
//   branch_correction   - on redirect: 1 = sequential PC, 0 = branch target
//   branch_count        - accepted resolves (BP_STATS_EN)
//   mispredict_count    - mispredicts (BP_STATS_EN)
//
// Build option: define BP_STATS_EN to enable the statistics counters;
// otherwise both statistics ports are tied to 0.
module branch_predictor #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16,
    parameter int DEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_F,
    input  logic             is_branch_F,
    input  logic             stall,
    input  logic             resolve_valid_EX,
    input  logic             taken_EX,
    output logic             branch_en_F,
    output logic             branch_en_EX,
    output logic             branch_correction,
    output logic [31:0]      branch_count,
    output logic [31:0]      mispredict_count
);

    localparam int IW = $clog2(ENTRIES);

    logic [1:0]    ctr [ENTRIES];
    logic [IW-1:0] idx_F;

    logic [DEPTH-1:0] st_valid;
    logic [DEPTH-1:0] st_pred;
    logic [IW-1:0]    st_idx [DEPTH];

    logic          head_valid;
    logic          head_pred;
    logic [IW-1:0] head_idx;
    logic          accept;
    logic          mispredict;
    logic          update;

    // Word-aligned PC: the low two bits and the bits above the index
    // do not take part in the lookup.
    logic unused_pc;
    assign unused_pc = ^{pc_F[WIDTH-1:IW+2], pc_F[1:0]};

    assign idx_F = pc_F[IW+1:2];

    assign head_valid = st_valid[DEPTH-1];
    // An invalid head behaves as a not-taken prediction.
    assign head_pred  = st_valid[DEPTH-1] & st_pred[DEPTH-1];
    assign head_idx   = st_idx[DEPTH-1];

    assign accept     = resolve_valid_EX & ~stall;
    assign mispredict = ~rst & accept & (head_pred ^ taken_EX);
    assign update     = accept & head_valid;

    assign branch_en_F       = ~rst & is_branch_F & ctr[idx_F][1];
    assign branch_en_EX      = mispredict;
    assign branch_correction = mispredict & head_pred & ~taken_EX;

    // Pattern table. Reads are combinational from the current state, so
    // a same-cycle lookup of the updated index sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (update) begin
            if (taken_EX) begin
                if (ctr[head_idx] != 2'b11) begin
                    ctr[head_idx] <= ctr[head_idx] + 2'b01;
                end
            end else begin
                if (ctr[head_idx] != 2'b00) begin
                    ctr[head_idx] <= ctr[head_idx] - 2'b01;
                end
            end
        end
    end

    // Valid bits: a flush wins over both stall and the new capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_valid <= '0;
        end else if (mispredict) begin
            st_valid <= '0;
        end else if (!stall) begin
            for (int i = DEPTH-1; i > 0; i--) begin
                st_valid[i] <= st_valid[i-1];
            end
            st_valid[0] <= is_branch_F;
        end
    end

    // Payload needs no reset: it is ignored while its valid bit is 0.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = DEPTH-1; i > 0; i--) begin
                st_pred[i] <= st_pred[i-1];
                st_idx[i]  <= st_idx[i-1];
            end
            st_pred[0] <= branch_en_F;
            st_idx[0]  <= idx_F;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (accept) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16: number of pattern-table entries, a power of two.
REQ-003 SHALL have parameter DEPTH, default 2: number of cycles from fetch to execute.
REQ-004 SHALL have clk  input  1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have rst  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have pc_F  input  WIDTH: PC of the instruction in fetch.
REQ-007 SHALL have is_branch_F  input  1: the fetch instruction is a conditional branch.
REQ-008 SHALL have stall  input  1: pipeline freeze.
REQ-009 SHALL have resolve_valid_EX  input  1: a branch is resolving in EX this cycle.
REQ-010 SHALL have taken_EX  input  1: actual outcome of the resolving branch.
REQ-011 SHALL have branch_en_F  output  1: predict taken in fetch.
REQ-012 SHALL have branch_en_EX  output  1: mispredict, redirect required.
REQ-013 SHALL have branch_correction  output  1: on redirect, 1 selects the sequential PC and 0 selects the branch target.
REQ-014 SHALL have branch_count  output  32 and mispredict_count  output  32: statistics counters.

Function
REQ-015 SHALL hold ENTRIES 2-bit saturating counters indexed by pc_F[log2(ENTRIES)+1:2]; predict taken when the counter MSB is 1.
REQ-016 SHALL drive branch_en_F combinationally as is_branch_F AND counter[idx][1]; it is 0 whenever is_branch_F is 0.
REQ-017 SHALL carry {valid, pred, idx} through a DEPTH-stage shift pipeline; stage 0 captures {is_branch_F, branch_en_F, idx} on every edge with stall=0; the head is stage DEPTH-1.
REQ-018 SHALL hold every pipeline stage unchanged when stall=1 and ignore resolve_valid_EX in that cycle.
REQ-019 SHALL define mispredict combinationally as resolve_valid_EX AND NOT stall AND (head.pred XOR taken_EX); an invalid head counts as pred=0.
REQ-020 SHALL drive branch_en_EX = mispredict and branch_correction = mispredict AND head.pred AND NOT taken_EX; both are 0 when mispredict is 0.
REQ-021 SHALL, on a mispredict edge, clear valid in all stages including the stage-0 capture; the flush overrides stall.
REQ-022 SHALL, on an edge with resolve_valid_EX=1, stall=0 and head.valid=1, increment counter[head.idx] if taken_EX=1 and decrement it otherwise, saturating at 3 and 0.
REQ-023 SHALL return the pre-update counter value when a fetch lookup and an update target the same index in the same cycle; the new value is visible from the next cycle.

Reset
REQ-024 SHALL on rst=1 immediately set all counters to 2'b01, clear all pipeline valid bits, and zero both statistics counters.
REQ-025 SHALL force branch_en_F, branch_en_EX and branch_correction to 0 while rst=1, including when reset is asserted mid-operation.

Configuration
REQ-026 SHALL, when BP_STATS_EN is defined, increment branch_count on every accepted resolve and mispredict_count on every mispredict, each wrapping modulo 2^32.
REQ-027 SHALL, when BP_STATS_EN is undefined, keep the statistics ports and drive them constant 0 with no counter logic.

Verification
REQ-028 SHALL cover: after reset, pc_F=0x40 with is_branch_F=1 -> branch_en_F=0 (counter 01).
REQ-029 SHALL cover: branch at 0x40 resolved taken twice -> counter 11; next fetch of 0x40 -> branch_en_F=1.
REQ-030 SHALL cover: predicted-taken branch resolves not-taken -> branch_en_EX=1 and branch_correction=1 for one cycle; pipeline valids 0 next cycle.
REQ-031 SHALL cover: predicted-not-taken branch resolves taken -> branch_en_EX=1, branch_correction=0, counter 01->10.
REQ-032 SHALL cover: stall=1 for 3 cycles with resolve_valid_EX=1 -> no counter change, head held, branch_en_EX=0.
REQ-033 SHALL cover: with BP_STATS_EN, 5 resolves including 2 mispredicts -> branch_count=5 and mispredict_count=2; rst mid-run -> all 0.
